// File: rtl/hs_bus_arbiter.sv
// hs_bus_arbiter
//   Shares one handshake slave port between two handshake masters
//   (m0 = instruction port, m1 = data port). Round-robin arbitration,
//   zero-wait completion in the arbitration cycle, grant locked while the
//   slave stalls, and a watchdog that aborts a hung transfer with an error.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-low reset
//   mN_rd_i / mN_wr_i       master N read / write request (level)
//   mN_addr_i / mN_wdata_i  master N address / write data
//   mN_ready_o              1 = idle, or master N request completes now
//   mN_rdata_o              read data to master N (0 unless N is the winner)
//   mN_err_o                one-cycle watchdog abort flag, with mN_ready_o
//   s_rd_o / s_wr_o         slave read / write request
//   s_addr_o / s_wdata_o    slave address / write data
//   s_ready_i / s_rdata_i   slave completion / read data
//
// State
//   lock | meaning
//   -----+------------------------------------------------------------
//   OFF  | arbitrate every cycle among current requesters
//   ON   | slave stalled; grant held on gnt_q, watchdog counting
module hs_bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1023,
   parameter int CNT_W   = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              m0_rd_i,
   input  logic              m0_wr_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_ready_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   output logic              m0_err_o,
   input  logic              m1_rd_i,
   input  logic              m1_wr_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_ready_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              m1_err_o,
   output logic              s_rd_o,
   output logic              s_wr_o,
   output logic [ADDR_W-1:0] s_addr_o,
   output logic [DATA_W-1:0] s_wdata_o,
   input  logic              s_ready_i,
   input  logic [DATA_W-1:0] s_rdata_i
);

   localparam logic LOCK_OFF = 1'b0;
   localparam logic LOCK_ON  = 1'b1;

   localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT);
   // With the watchdog disabled the counter just parks at all-ones.
   localparam logic [CNT_W-1:0] CNT_SAT = (TIMEOUT != 0) ? CNT_W'(TIMEOUT) : {CNT_W{1'b1}};

   logic             lock_q, lock_d;
   logic             gnt_q, gnt_d;
   logic             prio_q, prio_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic req0, req1, req_g;
   logic win_vld, win, abort, pass;

   always_comb begin
      req0  = m0_rd_i | m0_wr_i;
      req1  = m1_rd_i | m1_wr_i;
      req_g = gnt_q ? req1 : req0;

      win_vld = 1'b0;
      win     = 1'b0;
      if (lock_q == LOCK_ON) begin
         // A granted master that drops its request loses the slave at once.
         win_vld = req_g;
         win     = gnt_q;
      end else begin
         win_vld = req0 | req1;
         win     = (req0 & req1) ? prio_q : req1;
      end
      // Holding reset withdraws any request from the slave.
      if (!rst_i) begin
         win_vld = 1'b0;
      end

      abort = win_vld && (lock_q == LOCK_ON) && !s_ready_i &&
              (TIMEOUT != 0) && (cnt_q == CNT_TMO);
      pass  = win_vld & ~abort;

      s_rd_o    = pass & (win ? m1_rd_i : m0_rd_i);
      s_wr_o    = pass & (win ? m1_wr_i : m0_wr_i);
      s_addr_o  = win_vld ? (win ? m1_addr_i : m0_addr_i) : '0;
      s_wdata_o = win_vld ? (win ? m1_wdata_i : m0_wdata_i) : '0;

      m0_ready_o = !req0 ? 1'b1 : ((win_vld && !win) ? (s_ready_i | abort) : 1'b0);
      m1_ready_o = !req1 ? 1'b1 : ((win_vld &&  win) ? (s_ready_i | abort) : 1'b0);
      m0_rdata_o = (win_vld && !win) ? s_rdata_i : '0;
      m1_rdata_o = (win_vld &&  win) ? s_rdata_i : '0;
      m0_err_o   = abort & ~win;
      m1_err_o   = abort &  win;
   end

   always_comb begin
      lock_d = lock_q;
      gnt_d  = gnt_q;
      prio_d = prio_q;
      cnt_d  = cnt_q;
      if (lock_q == LOCK_OFF) begin
         if (win_vld) begin
            if (s_ready_i) begin
               prio_d = ~win;
            end else begin
               lock_d = LOCK_ON;
               gnt_d  = win;
               cnt_d  = CNT_W'(1);
            end
         end
      end else begin
         if (!req_g) begin
            // Protocol violation: release without touching priority.
            lock_d = LOCK_OFF;
            cnt_d  = '0;
         end else if (s_ready_i || abort) begin
            lock_d = LOCK_OFF;
            cnt_d  = '0;
            prio_d = ~gnt_q;
         end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         lock_q <= LOCK_OFF;
         gnt_q  <= 1'b0;
         prio_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         lock_q <= lock_d;
         gnt_q  <= gnt_d;
         prio_q <= prio_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hs_bus_arbiter.sv
// Directed bench for hs_bus_arbiter (watchdog TIMEOUT=8).
module tb_hs_bus_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        m0_rd_i, m0_wr_i, m1_rd_i, m1_wr_i;
   logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
   logic        m0_ready_o, m0_err_o, m1_ready_o, m1_err_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        s_rd_o, s_wr_o, s_ready_i;
   logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;

   int checks = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   hs_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .CNT_W(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_rd_i(m0_rd_i), .m0_wr_i(m0_wr_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
      .m0_ready_o(m0_ready_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
      .m1_rd_i(m1_rd_i), .m1_wr_i(m1_wr_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
      .m1_ready_o(m1_ready_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
      .s_rd_o(s_rd_o), .s_wr_o(s_wr_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
      .s_ready_i(s_ready_i), .s_rdata_i(s_rdata_i)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_reqs();
      m0_rd_i = 0; m0_wr_i = 0; m0_addr_i = 0; m0_wdata_i = 0;
      m1_rd_i = 0; m1_wr_i = 0; m1_addr_i = 0; m1_wdata_i = 0;
   endtask

   initial begin
      clear_reqs();
      rst_i = 0; s_ready_i = 0; s_rdata_i = 32'h1234_5678;
      tick(); tick(); #1;
      // reset state, no requests
      chk_eq("rst_s_rd", s_rd_o, 0);
      chk_eq("rst_s_wr", s_wr_o, 0);
      chk_eq("rst_s_addr", s_addr_o, 0);
      chk_eq("rst_s_wdata", s_wdata_o, 0);
      chk_eq("rst_m0_ready", m0_ready_o, 1);
      chk_eq("rst_m1_ready", m1_ready_o, 1);
      chk_eq("rst_m0_rdata", m0_rdata_o, 0);
      chk_eq("rst_m1_rdata", m1_rdata_o, 0);
      chk_eq("rst_m0_err", m0_err_o, 0);
      chk_eq("rst_m1_err", m1_err_o, 0);
      rst_i = 1;
      tick();

      // T1 zero-wait read on m0
      m0_rd_i = 1; m0_addr_i = 32'h100; s_ready_i = 1; s_rdata_i = 32'hDEADBEEF;
      #1;
      chk_eq("t1_s_rd", s_rd_o, 1);
      chk_eq("t1_s_addr", s_addr_o, 32'h100);
      chk_eq("t1_m0_ready", m0_ready_o, 1);
      chk_eq("t1_m0_rdata", m0_rdata_o, 32'hDEADBEEF);
      chk_eq("t1_m1_rdata", m1_rdata_o, 0);
      tick();

      // T3 round robin, prio now 1: m1,m0,m1,m0
      m0_rd_i = 1; m0_addr_i = 32'h200;
      m1_wr_i = 1; m1_addr_i = 32'h300; m1_wdata_i = 32'h55;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk_eq($sformatf("t3_s_addr_%0d", i), s_addr_o, (i % 2 == 0) ? 32'h300 : 32'h200);
         chk_eq($sformatf("t3_s_wr_%0d", i), s_wr_o, (i % 2 == 0) ? 1 : 0);
         chk_eq($sformatf("t3_m1_ready_%0d", i), m1_ready_o, (i % 2 == 0) ? 1 : 0);
         chk_eq($sformatf("t3_m0_ready_%0d", i), m0_ready_o, (i % 2 == 0) ? 0 : 1);
         tick();
      end
      clear_reqs(); s_ready_i = 0;
      rst_i = 0; tick(); rst_i = 1; tick();

      // T2 contention after reset, slave ready on 4th cycle
      m0_rd_i = 1; m0_addr_i = 32'h10;
      m1_wr_i = 1; m1_addr_i = 32'h20; m1_wdata_i = 32'hAA;
      for (int i = 0; i < 4; i++) begin
         s_ready_i = (i == 3);
         #1;
         chk_eq($sformatf("t2_s_addr_%0d", i), s_addr_o, 32'h10);
         chk_eq($sformatf("t2_m1_ready_%0d", i), m1_ready_o, 0);
         chk_eq($sformatf("t2_m0_ready_%0d", i), m0_ready_o, (i == 3) ? 1 : 0);
         tick();
      end
      m0_rd_i = 0;
      #1;
      chk_eq("t2_s_wr", s_wr_o, 1);
      chk_eq("t2_s_rd", s_rd_o, 0);
      chk_eq("t2_s_addr_m1", s_addr_o, 32'h20);
      chk_eq("t2_s_wdata", s_wdata_o, 32'hAA);
      chk_eq("t2_m1_ready_done", m1_ready_o, 1);
      tick();
      clear_reqs(); s_ready_i = 0;
      tick();

      // T4 watchdog abort on m1 at cycle 8
      m1_rd_i = 1; m1_addr_i = 32'h40;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin m0_rd_i = 1; m0_addr_i = 32'h50; end
         #1;
         chk_eq($sformatf("t4_m1_ready_%0d", i), m1_ready_o, 0);
         chk_eq($sformatf("t4_m1_err_%0d", i), m1_err_o, 0);
         chk_eq($sformatf("t4_s_rd_%0d", i), s_rd_o, 1);
         tick();
      end
      #1;
      chk_eq("t4_abort_m1_ready", m1_ready_o, 1);
      chk_eq("t4_abort_m1_err", m1_err_o, 1);
      chk_eq("t4_abort_s_rd", s_rd_o, 0);
      chk_eq("t4_abort_m0_ready", m0_ready_o, 0);
      chk_eq("t4_abort_m0_err", m0_err_o, 0);
      tick();
      m1_rd_i = 0; s_ready_i = 1;
      #1;
      chk_eq("t4_next_s_addr", s_addr_o, 32'h50);
      chk_eq("t4_next_m0_ready", m0_ready_o, 1);
      chk_eq("t4_next_m1_err", m1_err_o, 0);
      tick();
      clear_reqs(); s_ready_i = 0;
      tick();

      // T5 reset while locked on m1 (prio is 1 before reset)
      m1_wr_i = 1; m1_addr_i = 32'h60;
      tick(); tick();
      rst_i = 0;
      #1;
      chk_eq("t5_rst_s_wr", s_wr_o, 0);
      chk_eq("t5_rst_m1_err", m1_err_o, 0);
      tick();
      rst_i = 1; clear_reqs();
      #1;
      chk_eq("t5_m0_ready", m0_ready_o, 1);
      chk_eq("t5_m1_ready", m1_ready_o, 1);
      chk_eq("t5_s_wr", s_wr_o, 0);
      chk_eq("t5_s_rd", s_rd_o, 0);
      tick();
      m0_rd_i = 1; m0_addr_i = 32'h61; m1_rd_i = 1; m1_addr_i = 32'h62; s_ready_i = 1;
      #1;
      chk_eq("t5_cont_s_addr", s_addr_o, 32'h61);
      chk_eq("t5_cont_m1_ready", m1_ready_o, 0);
      tick();
      #1;
      chk_eq("t5_cont2_s_addr", s_addr_o, 32'h62);
      tick();
      clear_reqs(); s_ready_i = 0;
      tick();

      // T6 granted m0 drops request while locked (prio is 0 here)
      m0_rd_i = 1; m0_addr_i = 32'h70;
      tick();
      m0_rd_i = 0;
      #1;
      chk_eq("t6_drop_s_rd", s_rd_o, 0);
      chk_eq("t6_drop_m0_ready", m0_ready_o, 1);
      chk_eq("t6_drop_m0_err", m0_err_o, 0);
      tick();
      m0_rd_i = 1; m0_addr_i = 32'h71; m1_rd_i = 1; m1_addr_i = 32'h72; s_ready_i = 1;
      #1;
      chk_eq("t6_next_s_addr", s_addr_o, 32'h71);
      chk_eq("t6_next_m0_ready", m0_ready_o, 1);
      chk_eq("t6_next_m1_ready", m1_ready_o, 0);
      tick();
      clear_reqs(); s_ready_i = 0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
